mul_tree_result_collector: RTL and testbench
============================================

# mul_tree_result_collector

Downstream stage of the bf16 multiplier tree. Captures the per-lane products presented on the tree's `outputs` bus with their per-lane strobes, aligns lanes that complete in different cycles into one result set according to the active `mode`, and buffers completed sets in a small FIFO. The FIFO drains over a valid/ready handshake toward the accumulation/write-back logic. The tree has no backpressure, so the collector never stalls it; sets that cannot be buffered are dropped and counted.

## Interface
- `DW`, 16: width of one lane result (bf16).
- `DEPTH`, 4: FIFO depth in result sets; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  2  tree mode; same encoding as the tree's `mode` input.
- `in_data`  in  4*DW  tree `outputs`; lane k = bits [k*DW +: DW].
- `in_stbs`  in  4  tree `final_output_stbs_1`; bit k qualifies lane k for one cycle.
- `out_data`  out  4*DW  head-of-FIFO set; inactive lanes are zero.
- `out_mask`  out  4  active-lane mask of the head set.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head set when `out_valid & out_ready`.
- `overflow`  out  1  sticky; a completed set was dropped because the FIFO was full.
- `collision`  out  1  sticky; a strobe hit a lane that was already pending.
- `drop_cnt`  out  8  saturating count of dropped sets.

## Operation
- Active-lane mask from `mode`: 00 → 4'b1111; 01 → 4'b0101; 10 → 4'b0001; 11 is reserved and treated as 00.
- Per lane: holding register `hold[k]` and flag `pend[k]`. Strobes on inactive lanes are ignored.
- A set completes in any cycle where every active lane satisfies `pend[k] | in_stbs[k]`. Lane data for the set is `in_data` lane k if strobed this cycle, otherwise `hold[k]` (bypass). On completion, all `pend` clear and the set is written to the FIFO with its mask.
- If a set does not complete, each strobed active lane loads `hold[k]` and sets `pend[k]`.
- Collision: a strobe on an active lane with `pend[k]=1` when the set does not complete sets `collision`. The new value overwrites `hold[k]`.
- FIFO write and read in the same cycle are both allowed, including when the FIFO is full. The read frees the slot, so the write succeeds.
- If the FIFO is full and there is no read, the completed set is discarded, `overflow` sets, and `drop_cnt` increments, saturating at 255.
- If `mode` differs from its value registered on the previous cycle, all `pend` clear and the partial set is discarded with no flag. Strobes in that same cycle are evaluated against the new mask.
- Sticky flags clear only on reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_mask`=0, `overflow`=0, `collision`=0, `drop_cnt`=0, all `pend`=0, FIFO empty, registered mode=00.
- Latency: a completing strobe sampled at edge N gives `out_valid`=1 after edge N, provided the FIFO was empty.
- `out_data` and `out_mask` are driven from registers/FIFO storage, with no combinational path from `in_*`. They hold stable while `out_valid & ~out_ready`.
- Throughput: one set per cycle in, one set per cycle out.
- Pointer wrap-around uses an extra MSB bit. Full is signalled when the pointers are equal except for the MSB.
- Reset asserted mid-operation empties the FIFO and clears pending lanes and all flags immediately, asynchronously.

## Structure
- Shared package `mul_tree_pkg`: `DW` default, the mode encoding enum (`MODE_4L`, `MODE_2L`, `MODE_1L`, `MODE_RSV`), and the `lane_mask(mode)` function. The tree and the collector both use this package.
- One sub-module: `sync_fifo`, parameterized by width (4*DW+4) and `DEPTH`, with `wr_en`, `rd_en`, `full`, `empty`.

## Test plan
- Mode 00, all four strobes in one cycle with lanes 0x3F80, 0x4000, 0x4040, 0x4080 → one cycle later `out_valid`=1, `out_data`={4080,4040,4000,3F80}, `out_mask`=1111.
- Mode 00, strobes on lanes 0/1 at cycle 0 and lanes 2/3 at cycle 2 → exactly one set after cycle 2 with all four values; no `collision`.
- Mode 01, strobes on lanes 0 and 2 (lanes 1 and 3 also strobed with 0xFFFF) → set has `out_mask`=0101 and lanes 1 and 3 equal 0.
- `out_ready`=0, 6 complete sets with DEPTH=4 → 4 buffered, `overflow`=1, `drop_cnt`=2. Then `out_ready`=1 → the first 4 sets drain in order and `out_valid` falls.
- Lane 0 strobed twice (0x1111 then 0x2222) before lane 1–3 strobes → `collision`=1 and the set carries 0x2222 on lane 0.
- Lane 0 pending, `mode` changes 00→10, next cycle lane 0 strobed with 0x5555 → single set {0,0,0,5555}, mask 0001, with no stale data. Asserting `rst` with 3 sets buffered → `out_valid`=0 immediately.

Source files
------------

// File: rtl/mul_tree_pkg.sv
// rtl/mul_tree_pkg.sv - shared types and helpers for the bf16 multiplier tree and its collector
package mul_tree_pkg;

    localparam int DEFAULT_DW = 16;

    typedef enum logic [1:0] {
        MODE_4L  = 2'b00,
        MODE_2L  = 2'b01,
        MODE_1L  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    // The reserved encoding behaves like the four-lane mode.
    function automatic logic [3:0] lane_mask(input logic [1:0] mode);
        logic [3:0] m;
        case (mode_e'(mode))
            MODE_2L: m = 4'b0101;
            MODE_1L: m = 4'b0001;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers and zeroed read data when empty
module sync_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Writing into the slot being read in the same cycle is safe: the read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mul_tree_result_collector.sv
// rtl/mul_tree_result_collector.sv - aligns per-lane tree products into result sets and buffers them
module mul_tree_result_collector
    import mul_tree_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [4*DW-1:0] in_data,
    input  logic [3:0]      in_stbs,
    output logic [4*DW-1:0] out_data,
    output logic [3:0]      out_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overflow,
    output logic            collision,
    output logic [7:0]      drop_cnt
);
    localparam int SW = 4*DW + 4;

    logic [1:0]      mode_q;
    logic [3:0]      pend;
    logic [DW-1:0]   hold [4];
    logic [3:0]      act_mask;
    logic [3:0]      pend_eff;
    logic [3:0]      stb_act;
    logic            complete;
    logic [4*DW-1:0] set_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            wr_en;
    logic            rd_en;
    logic            drop;
    logic [SW-1:0]   rd_word;

    // A mode change throws away the partial set; this cycle's strobes use the new mask.
    always_comb begin
        act_mask = lane_mask(mode);
        pend_eff = (mode != mode_q) ? 4'b0000 : pend;
        stb_act  = in_stbs & act_mask;
        complete = (((pend_eff | stb_act) & act_mask) == act_mask);
        set_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (stb_act[k])
                set_data[k*DW +: DW] = in_data[k*DW +: DW];
            else if (act_mask[k])
                set_data[k*DW +: DW] = hold[k];
        end
    end

    assign rd_en = ~fifo_empty & out_ready;
    assign wr_en = complete & (~fifo_full | rd_en);
    assign drop  = complete & fifo_full & ~rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_4L;
            pend      <= '0;
            collision <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            for (int k = 0; k < 4; k++) hold[k] <= '0;
        end else begin
            mode_q <= mode;
            if (complete) begin
                pend <= '0;
            end else begin
                pend <= pend_eff | stb_act;
                if (|(stb_act & pend_eff)) collision <= 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (stb_act[k]) hold[k] <= in_data[k*DW +: DW];
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({act_mask, set_data}),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_mask  = rd_word[SW-1 -: 4];
    assign out_data  = rd_word[4*DW-1:0];

endmodule

// File: tb/tb_mul_tree_result_collector.sv
// tb/tb_mul_tree_result_collector.sv - directed and randomized checks against a queue-based model
module tb_mul_tree_result_collector;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [63:0] in_data;
    logic [3:0]  in_stbs;
    logic [63:0] out_data;
    logic [3:0]  out_mask;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        collision;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    mul_tree_result_collector #(.DW(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_stbs   (in_stbs),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .collision (collision),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  mask;
    } set_t;

    set_t        m_q[$];
    logic [15:0] m_hold [4];
    bit   [3:0]  m_pend;
    int          m_prev;
    bit          m_ovf;
    bit          m_coll;
    int          m_drop;

    function automatic logic [3:0] m_mask(input int md);
        if (md == 1) return 4'b0101;
        if (md == 2) return 4'b0001;
        return 4'b1111;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend = '0;
        m_prev = 0;
        m_ovf  = 0;
        m_coll = 0;
        m_drop = 0;
        for (int k = 0; k < 4; k++) m_hold[k] = '0;
    endtask

    // Evaluates one cycle from the values presented before the coming edge.
    task automatic model_step();
        bit          rd = (m_q.size() > 0) && out_ready;
        int          md = int'(mode);
        logic [3:0]  m  = m_mask(md);
        bit          all_in = 1;
        set_t        s;
        if (md != m_prev) m_pend = '0;
        for (int k = 0; k < 4; k++)
            if (m[k] && !(m_pend[k] || in_stbs[k])) all_in = 0;
        if (rd) void'(m_q.pop_front());
        if (all_in) begin
            s.mask = m;
            s.data = '0;
            for (int k = 0; k < 4; k++)
                if (m[k]) s.data[k*16 +: 16] = in_stbs[k] ? in_data[k*16 +: 16] : m_hold[k];
            m_pend = '0;
            if (m_q.size() < DEPTH) m_q.push_back(s);
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m[k] && in_stbs[k]) begin
                    if (m_pend[k]) m_coll = 1;
                    m_hold[k] = in_data[k*16 +: 16];
                    m_pend[k] = 1;
                end
            end
        end
        m_prev = md;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        chk("valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("data",  out_data, (m_q.size() != 0) ? m_q[0].data : 64'h0);
        chk("mask",  64'(out_mask), (m_q.size() != 0) ? 64'(m_q[0].mask) : 64'h0);
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("collision", 64'(collision), 64'(m_coll));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_stbs   = '0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        chk("drained", 64'(out_valid), 64'h0);
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; in_data = '0; in_stbs = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data",  out_data, 64'h0);
        chk("rst_mask",  64'(out_mask), 64'h0);
        chk("rst_flags", {62'h0, overflow, collision}, 64'h0);
        chk("rst_drop",  64'(drop_cnt), 64'h0);
        rst = 1'b0;

        // all four lanes in one cycle
        in_data = 64'h4080_4040_4000_3F80; in_stbs = 4'b1111;
        tick();
        chk("one_shot_valid", 64'(out_valid), 64'h1);
        chk("one_shot_data",  out_data, 64'h4080_4040_4000_3F80);
        chk("one_shot_mask",  64'(out_mask), 64'hF);
        drain();

        // lanes arriving in different cycles
        out_ready = 1'b0;
        in_data = 64'h0000_0000_BBBB_AAAA; in_stbs = 4'b0011; tick();
        in_stbs = 4'b0000; tick();
        chk("split_not_yet", 64'(out_valid), 64'h0);
        in_data = 64'hDDDD_CCCC_0000_0000; in_stbs = 4'b1100; tick();
        chk("split_valid", 64'(out_valid), 64'h1);
        chk("split_data",  out_data, 64'hDDDD_CCCC_BBBB_AAAA);
        chk("split_coll",  64'(collision), 64'h0);
        out_ready = 1'b1; in_stbs = 4'b0000; tick();
        chk("split_single", 64'(out_valid), 64'h0);

        // overflow with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = {4{16'(16'h1000 + i)}}; in_stbs = 4'b1111; tick();
        end
        in_stbs = 4'b0000;
        chk("ovf_flag", 64'(overflow), 64'h1);
        chk("ovf_drop", 64'(drop_cnt), 64'h2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", out_data, {4{16'(16'h1000 + i)}});
            tick();
        end
        chk("ovf_empty", 64'(out_valid), 64'h0);

        // collision on lane 0
        out_ready = 1'b0;
        in_data = 64'h0000_0000_0000_1111; in_stbs = 4'b0001; tick();
        in_data = 64'h0000_0000_0000_2222; in_stbs = 4'b0001; tick();
        chk("coll_flag", 64'(collision), 64'h1);
        in_data = 64'h3333_3333_3333_0000; in_stbs = 4'b1110; tick();
        chk("coll_data", out_data, 64'h3333_3333_3333_2222);
        drain();

        // two-lane mode masks lanes 1 and 3
        out_ready = 1'b0; mode = 2'b01; in_stbs = 4'b0000; tick();
        in_data = 64'hFFFF_5678_FFFF_1234; in_stbs = 4'b1111; tick();
        chk("m01_mask", 64'(out_mask), 64'h5);
        chk("m01_data", out_data, 64'h0000_5678_0000_1234);
        drain();

        // mode change discards a pending lane
        out_ready = 1'b0; mode = 2'b00; in_stbs = 4'b0000; tick();
        in_data = 64'h0000_0000_0000_9999; in_stbs = 4'b0001; tick();
        mode = 2'b10; in_stbs = 4'b0000; tick();
        chk("mchg_none", 64'(out_valid), 64'h0);
        in_data = 64'h7777_7777_7777_5555; in_stbs = 4'b0001; tick();
        chk("mchg_data", out_data, 64'h0000_0000_0000_5555);
        chk("mchg_mask", 64'(out_mask), 64'h1);
        in_stbs = 4'b0001; tick(); tick();
        chk("three_buf", 64'(m_q.size() == 3 && out_valid), 64'h1);

        // asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_valid", 64'(out_valid), 64'h0);
        chk("async_flags", {62'h0, overflow, collision}, 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        mode = 2'b00; in_stbs = 4'b0000;

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            in_stbs   = 4'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
